// File: rtl/matmul_seq_pkg.sv
// Shared types and sizes for the matrix_multiplication host sequencer.
package matmul_seq_pkg;

  localparam int DWIDTH  = 8;
  localparam int MM_SIZE = 32;
  localparam int AWIDTH  = 7;
  localparam int ROW_W   = MM_SIZE * DWIDTH;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_A   = 3'd1,
    ST_LOAD_B   = 3'd2,
    ST_DRAIN_WR = 3'd3,
    ST_COMPUTE  = 3'd4,
    ST_UNLOAD   = 3'd5
  } seq_state_e;

endpackage

// File: rtl/seq_delay_line.sv
// Fixed-depth shift register that advances every cycle; clears on reset.
module seq_delay_line #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_mem,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/matmul_mem_sequencer.sv
// Loads A/B into matrix_multiplication, runs it, and streams C back out.
// Define SEQ_PERF_COUNTER_EN to add perf_compute_cycles / perf_job_cycles outputs.
module matmul_mem_sequencer
  import matmul_seq_pkg::*;
#(
  parameter int NUM_ROWS    = 32,
  parameter int WR_ADDR_LAT = 2,
  parameter int RD_LAT      = 4
) (
  input  logic              clk_mem,
  input  logic              reset,
  input  logic              cmd_start,
  output logic              busy,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ROW_W-1:0]  in_data,
  output logic              out_valid,
  output logic [ROW_W-1:0]  out_data,
  output logic              enable_writing_to_mem,
  output logic              enable_reading_from_mem,
  output logic [AWIDTH-1:0] addr_pi,
  output logic [ROW_W-1:0]  data_pi,
  output logic              we_a,
  output logic              we_b,
  output logic              we_c,
  output logic              start_mat_mul,
  input  logic              done_mat_mul,
  input  logic [ROW_W-1:0]  data_from_out_mat
`ifdef SEQ_PERF_COUNTER_EN
  ,
  output logic [31:0]       perf_compute_cycles,
  output logic [31:0]       perf_job_cycles
`endif
);

  localparam logic [AWIDTH-1:0] ROW_LAST = AWIDTH'(NUM_ROWS - 1);
  localparam int DCW = $clog2(WR_ADDR_LAT + 2);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(WR_ADDR_LAT);

  seq_state_e        state_q, state_d;
  logic [AWIDTH-1:0] row_cnt_q, row_cnt_d;
  logic [DCW-1:0]    drain_cnt_q, drain_cnt_d;
  logic [AWIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_all_q, rd_all_d;
  logic [AWIDTH-1:0] out_cnt_q, out_cnt_d;
  logic [ROW_W-1:0]  data_hold_q, data_hold_d;

  logic              hs;
  logic              rd_issue;
  logic [ROW_W+1:0]  wr_dl_in, wr_dl_out;

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      rd_cnt_q    <= '0;
      rd_all_q    <= 1'b0;
      out_cnt_q   <= '0;
      data_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_all_q    <= rd_all_d;
      out_cnt_q   <= out_cnt_d;
      data_hold_q <= data_hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_all_d    = rd_all_q;
    out_cnt_d   = out_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_start) begin
          state_d     = ST_LOAD_A;
          row_cnt_d   = '0;
          drain_cnt_d = '0;
          rd_cnt_d    = '0;
          rd_all_d    = 1'b0;
          out_cnt_d   = '0;
        end
      end
      ST_LOAD_A, ST_LOAD_B: begin
        if (hs) begin
          if (row_cnt_q == ROW_LAST) begin
            row_cnt_d   = '0;
            drain_cnt_d = '0;
            state_d     = (state_q == ST_LOAD_A) ? ST_LOAD_B : ST_DRAIN_WR;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      // Keep the write window open until the last we_b reaches the RAM, plus one idle cycle.
      ST_DRAIN_WR: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          drain_cnt_d = '0;
          state_d     = ST_COMPUTE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      ST_COMPUTE: begin
        if (done_mat_mul) begin
          state_d   = ST_UNLOAD;
          rd_cnt_d  = '0;
          rd_all_d  = 1'b0;
          out_cnt_d = '0;
        end
      end
      ST_UNLOAD: begin
        if (!rd_all_q) begin
          if (rd_cnt_q == ROW_LAST) begin
            rd_all_d = 1'b1;
          end else begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end
        if (out_valid) begin
          if (out_cnt_q == ROW_LAST) begin
            state_d   = ST_IDLE;
            rd_cnt_d  = '0;
            rd_all_d  = 1'b0;
            out_cnt_d = '0;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy                    = (state_q != ST_IDLE);
    in_ready                = (state_q == ST_LOAD_A) || (state_q == ST_LOAD_B);
    hs                      = in_valid && in_ready;
    enable_writing_to_mem   = in_ready ||
                              ((state_q == ST_DRAIN_WR) && (drain_cnt_q < DRAIN_LAST));
    enable_reading_from_mem = (state_q == ST_UNLOAD);
    start_mat_mul           = (state_q == ST_COMPUTE);
    we_c                    = (state_q == ST_COMPUTE);
    rd_issue                = (state_q == ST_UNLOAD) && !rd_all_q;
    addr_pi                 = '0;
    if (in_ready) begin
      addr_pi = row_cnt_q;
    end else if (state_q == ST_UNLOAD) begin
      addr_pi = rd_cnt_q;
    end
    wr_dl_in    = {hs && (state_q == ST_LOAD_A), hs && (state_q == ST_LOAD_B), in_data};
    we_a        = wr_dl_out[ROW_W+1];
    we_b        = wr_dl_out[ROW_W];
    data_pi     = (we_a || we_b) ? wr_dl_out[ROW_W-1:0] : data_hold_q;
    data_hold_d = data_pi;
    out_data    = out_valid ? data_from_out_mat : '0;
  end

  // Write strobes and data lag addr_pi by the core's registered address path.
  seq_delay_line #(.DEPTH(WR_ADDR_LAT), .WIDTH(ROW_W + 2)) u_wr_dl (
    .clk_mem (clk_mem),
    .reset   (reset),
    .din     (wr_dl_in),
    .dout    (wr_dl_out)
  );

  seq_delay_line #(.DEPTH(RD_LAT), .WIDTH(1)) u_rd_dl (
    .clk_mem (clk_mem),
    .reset   (reset),
    .din     (rd_issue),
    .dout    (out_valid)
  );

`ifdef SEQ_PERF_COUNTER_EN
  logic [31:0] perf_compute_q, perf_compute_d;
  logic [31:0] perf_job_q, perf_job_d;

  always_ff @(posedge clk_mem) begin
    if (reset) begin
      perf_compute_q <= '0;
      perf_job_q     <= '0;
    end else begin
      perf_compute_q <= perf_compute_d;
      perf_job_q     <= perf_job_d;
    end
  end

  always_comb begin
    perf_compute_d = perf_compute_q;
    perf_job_d     = perf_job_q;
    if ((state_q == ST_IDLE) && cmd_start) begin
      perf_compute_d = '0;
      perf_job_d     = '0;
    end else begin
      if ((state_q == ST_COMPUTE) && (perf_compute_q != '1)) perf_compute_d = perf_compute_q + 1'b1;
      if (busy && (perf_job_q != '1)) perf_job_d = perf_job_q + 1'b1;
    end
  end

  assign perf_compute_cycles = perf_compute_q;
  assign perf_job_cycles     = perf_job_q;
`endif

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// Bench for matmul_mem_sequencer: memory model of matrix_multiplication plus random jobs.
`timescale 1ns/1ps
module tb_matmul_mem_sequencer;
  import matmul_seq_pkg::*;

  localparam int NROWS    = 32;
  localparam int RLAT     = 4;
  localparam int DONE_DLY = 40;

  logic              clk_mem = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_start = 1'b0;
  logic              in_valid = 1'b0;
  logic              done_mat_mul = 1'b0;
  logic [ROW_W-1:0]  in_data = '0;
  logic              busy, in_ready, out_valid;
  logic [ROW_W-1:0]  out_data, data_pi, data_from_out_mat;
  logic              enable_writing_to_mem, enable_reading_from_mem;
  logic [AWIDTH-1:0] addr_pi;
  logic              we_a, we_b, we_c, start_mat_mul;
`ifdef SEQ_PERF_COUNTER_EN
  logic [31:0]       perf_compute_cycles, perf_job_cycles;
`endif

  always #5 clk_mem = ~clk_mem;

  matmul_mem_sequencer dut (
    .clk_mem                 (clk_mem),
    .reset                   (reset),
    .cmd_start               (cmd_start),
    .busy                    (busy),
    .in_valid                (in_valid),
    .in_ready                (in_ready),
    .in_data                 (in_data),
    .out_valid               (out_valid),
    .out_data                (out_data),
    .enable_writing_to_mem   (enable_writing_to_mem),
    .enable_reading_from_mem (enable_reading_from_mem),
    .addr_pi                 (addr_pi),
    .data_pi                 (data_pi),
    .we_a                    (we_a),
    .we_b                    (we_b),
    .we_c                    (we_c),
    .start_mat_mul           (start_mat_mul),
    .done_mat_mul            (done_mat_mul),
    .data_from_out_mat       (data_from_out_mat)
`ifdef SEQ_PERF_COUNTER_EN
    ,
    .perf_compute_cycles     (perf_compute_cycles),
    .perf_job_cycles         (perf_job_cycles)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural model of the core's memories: 2-cycle write address path, RLAT read path.
  logic [ROW_W-1:0]  amem [NROWS];
  logic [ROW_W-1:0]  bmem [NROWS];
  logic [ROW_W-1:0]  cmem [NROWS];
  logic [AWIDTH-1:0] wa_p1 = '0, wa_p2 = '0;
  logic [AWIDTH-1:0] ra_p [RLAT];

  always @(posedge clk_mem) begin
    wa_p1 <= addr_pi;
    wa_p2 <= wa_p1;
    if (we_a) amem[wa_p2[4:0]] <= data_pi;
    if (we_b) bmem[wa_p2[4:0]] <= data_pi;
    ra_p[0] <= addr_pi;
    for (int i = 1; i < RLAT; i++) ra_p[i] <= ra_p[i-1];
  end
  assign data_from_out_mat = cmem[ra_p[RLAT-1][4:0]];

  // Per-job statistics gathered mid-cycle.
  int cyc = 0;
  int n_we_a, n_we_b, n_start, n_we_c, n_busy, n_out, n_hs;
  int first_hs_cyc, first_we_cyc, last_start_cyc, first_rd_cyc, first_out_cyc, last_out_cyc;
  logic [1:0] h1 = 2'b00, h2 = 2'b00, hcode;

  always @(negedge clk_mem) begin
    cyc++;
    check("we_align", ROW_W'({we_a, we_b}), ROW_W'(h2));
    if (in_valid && in_ready) begin
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      hcode = (n_hs < NROWS) ? 2'b10 : 2'b01;
      n_hs++;
    end else begin
      hcode = 2'b00;
    end
    if ((we_a || we_b) && first_we_cyc < 0) first_we_cyc = cyc;
    h2 = reset ? 2'b00 : h1;
    h1 = reset ? 2'b00 : hcode;
    if (we_a) n_we_a++;
    if (we_b) n_we_b++;
    if (start_mat_mul) begin
      n_start++;
      last_start_cyc = cyc;
    end
    if (we_c) n_we_c++;
    if (busy) n_busy++;
    if (enable_reading_from_mem && first_rd_cyc < 0) first_rd_cyc = cyc;
    if (out_valid) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      last_out_cyc = cyc;
      check("out_row", out_data, (n_out < NROWS) ? cmem[n_out] : '0);
      n_out++;
    end
  end

  task automatic tick();
    @(posedge clk_mem);
    #1;
  endtask

  task automatic clear_stats();
    n_we_a = 0; n_we_b = 0; n_start = 0; n_we_c = 0; n_busy = 0; n_out = 0; n_hs = 0;
    first_hs_cyc = -1; first_we_cyc = -1; last_start_cyc = -1;
    first_rd_cyc = -1; first_out_cyc = -1; last_out_cyc = -1;
  endtask

  function automatic logic [ROW_W-1:0] rand_row();
    logic [ROW_W-1:0] r;
    for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctrl"}, ROW_W'({busy, in_ready, out_valid, enable_writing_to_mem,
                                  enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul, addr_pi}), '0);
    check({tag, "_data_pi"}, data_pi, '0);
    check({tag, "_out_data"}, out_data, '0);
  endtask

  task automatic run_job(input string name, input bit bubbled, input bit patterned, input int abort_at);
    logic [ROW_W-1:0] rows [2*NROWS];
    logic [7:0] k;
    int idx, guard;
    bit hs;
    for (int i = 0; i < 2*NROWS; i++) begin
      k = 8'(i);
      rows[i] = (patterned && i < NROWS) ? {MM_SIZE{k}} : rand_row();
    end
    clear_stats();
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    idx = 0;
    guard = 0;
    while (idx < 2*NROWS && guard < 400) begin
      if (abort_at >= 0 && idx == NROWS + abort_at) break;
      in_valid     = bubbled ? (guard % 2 == 0) : 1'b1;
      in_data      = rows[idx];
      done_mat_mul = bubbled && (guard == 7);
      hs = in_valid && in_ready;
      tick();
      if (hs) idx++;
      guard++;
    end
    in_valid     = 1'b0;
    done_mat_mul = 1'b0;

    if (abort_at >= 0) begin
      reset     = 1'b1;
      cmd_start = 1'b1;
      tick();
      reset     = 1'b0;
      cmd_start = 1'b0;
      check_idle_outputs("abort");
      tick();
      check("abort_stay_idle", ROW_W'(busy), '0);
      $display("%s: aborted at B row %0d, busy=%0b", name, abort_at, busy);
      return;
    end

    check({name, "_rows_accepted"}, ROW_W'(idx), ROW_W'(2*NROWS));
    guard = 0;
    while (!start_mat_mul && guard < 20) begin
      tick();
      guard++;
    end
    check({name, "_start_seen"}, ROW_W'(start_mat_mul), ROW_W'(1));
    repeat (DONE_DLY) tick();
    done_mat_mul = 1'b1;
    tick();
    done_mat_mul = 1'b0;
    guard = 0;
    while (busy && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "_busy_fall"}, ROW_W'(busy), '0);
    tick();

    check({name, "_we_a_cnt"}, ROW_W'(n_we_a), ROW_W'(NROWS));
    check({name, "_we_b_cnt"}, ROW_W'(n_we_b), ROW_W'(NROWS));
    check({name, "_we_lat"}, ROW_W'(first_we_cyc - first_hs_cyc), ROW_W'(2));
    check({name, "_start_len"}, ROW_W'(n_start), ROW_W'(DONE_DLY + 1));
    check({name, "_we_c_len"}, ROW_W'(n_we_c), ROW_W'(DONE_DLY + 1));
    check({name, "_out_cnt"}, ROW_W'(n_out), ROW_W'(NROWS));
    check({name, "_rd_lat"}, ROW_W'(first_out_cyc - first_rd_cyc), ROW_W'(RLAT));
    check({name, "_unload_lat"}, ROW_W'(first_out_cyc - last_start_cyc), ROW_W'(RLAT + 1));
    check({name, "_out_contig"}, ROW_W'(last_out_cyc - first_out_cyc), ROW_W'(NROWS - 1));
    for (int r = 0; r < NROWS; r++) begin
      check({name, "_amem"}, amem[r], rows[r]);
      check({name, "_bmem"}, bmem[r], rows[NROWS + r]);
    end
`ifdef SEQ_PERF_COUNTER_EN
    check({name, "_perf_compute"}, ROW_W'(perf_compute_cycles), ROW_W'(DONE_DLY + 1));
    check({name, "_perf_job"}, ROW_W'(perf_job_cycles), ROW_W'(n_busy));
`endif
    $display("%s: we_a=%0d we_b=%0d start=%0d out=%0d busy_cycles=%0d",
             name, n_we_a, n_we_b, n_start, n_out, n_busy);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    for (int r = 0; r < NROWS; r++) begin
      b = 8'(r + 16);
      cmem[r] = {MM_SIZE{b}};
      amem[r] = '0;
      bmem[r] = '0;
    end
    for (int i = 0; i < RLAT; i++) ra_p[i] = '0;
    clear_stats();

    reset = 1'b1;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    $display("reset: busy=%0b in_ready=%0b", busy, in_ready);

    run_job("b2b_load", 1'b0, 1'b1, -1);
    run_job("bubbled", 1'b1, 1'b0, -1);
    run_job("abort_b10", 1'b0, 1'b0, 10);
    run_job("fresh_job", 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
